// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon permutation engine.
//   state_t          : five 64-bit words, x0 in the most significant slot
//   ASCON_MAX_ROUNDS : round count of the full permutation p^12
//   ROUND_CONST      : the twelve round constants, indexed by round number
//   fsm_e            : engine FSM states, used for the debug output
//   round_const()    : bounded lookup into ROUND_CONST
package ascon_pkg;

  typedef logic [0:4][63:0] state_t;

  localparam int unsigned ASCON_MAX_ROUNDS = 12;

  localparam logic [7:0] ROUND_CONST [12] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  typedef enum logic [0:0] {
    FSM_IDLE = 1'b0,
    FSM_BUSY = 1'b1
  } fsm_e;

  // Indices past the table only occur on idle cycles where the round
  // output is discarded, so returning zero there is harmless.
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    return (idx < 4'd12) ? ROUND_CONST[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/ascon_perm_engine_if.sv
// Request/status bundle of the Ascon permutation engine.
//   master : requester side (drives start_i, rounds_i, abort_i, state_i)
//   slave  : engine side (drives ready_o, busy_o, state_o, update_state_o,
//            done_o, err_o, fsm_dbg_o)
// Handshake: a request transfers on a rising clk edge where start_i=1 and
// ready_o=1 (with abort_i=0); rounds_i and state_i are sampled only on that
// edge. Completion is signalled by a one-cycle done_o pulse, a rejected
// request by a one-cycle err_o pulse; no back-pressure exists on either.
interface ascon_perm_engine_if;
  import ascon_pkg::*;

  logic       start_i;
  logic [3:0] rounds_i;
  logic       abort_i;
  state_t     state_i;
  logic       ready_o;
  logic       busy_o;
  state_t     state_o;
  logic       update_state_o;
  logic       done_o;
  logic       err_o;
  fsm_e       fsm_dbg_o;

  modport master (
    output start_i, rounds_i, abort_i, state_i,
    input  ready_o, busy_o, state_o, update_state_o, done_o, err_o, fsm_dbg_o
  );

  modport slave (
    input  start_i, rounds_i, abort_i, state_i,
    output ready_o, busy_o, state_o, update_state_o, done_o, err_o, fsm_dbg_o
  );

endinterface

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, 5-bit S-box layer
// (bit-sliced boolean form), linear diffusion layer.
//   state_i : state entering the round
//   rc_i    : round constant XORed into the low byte of x2
//   state_o : state leaving the round
module ascon_round
  import ascon_pkg::*;
(
  input  state_t     state_i,
  input  logic [7:0] rc_i,
  output state_t     state_o
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  always_comb begin
    x0 = state_i[0];
    x1 = state_i[1];
    x2 = state_i[2] ^ {56'h0, rc_i};
    x3 = state_i[3];
    x4 = state_i[4];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    state_o[0] = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    state_o[1] = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    state_o[2] = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    state_o[3] = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    state_o[4] = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
  end

endmodule

// File: rtl/ascon_perm_engine.sv
// Iterative Ascon permutation p^a with UNROLL rounds per clock.
// Optional feature macro: ASCON_PERM_INTR_EN adds a sticky completion
// interrupt (intr_o) and its clear input (intr_clr_i).
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   bus            : ascon_perm_engine_if.slave request/status bundle
//   intr_clr_i     : clears intr_o (interrupt build only)
//   intr_o         : set by done_o, held until cleared (interrupt build only)
// A request for r rounds runs the last r rounds of p^12, i.e. round
// constants MAX_ROUNDS-r .. MAX_ROUNDS-1.
module ascon_perm_engine
  import ascon_pkg::*;
#(
  parameter int unsigned UNROLL     = 1,
  parameter int unsigned MAX_ROUNDS = ASCON_MAX_ROUNDS
) (
  input  logic clk_i,
  input  logic rst_n_i,
`ifdef ASCON_PERM_INTR_EN
  input  logic intr_clr_i,
  output logic intr_o,
`endif
  ascon_perm_engine_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0] fsm_q;
  logic [3:0] idx_q;
  state_t     state_q;
  logic       done_q;
  logic       err_q;

  logic       legal;
  logic [3:0] idx_next;
  logic       last_step;
  state_t     chain [UNROLL+1];

  assign legal = (bus.rounds_i != 4'd0) &&
                 (bus.rounds_i <= 4'(MAX_ROUNDS)) &&
                 ((UNROLL == 1) || !bus.rounds_i[0]);

  assign idx_next  = idx_q + 4'(UNROLL);
  assign last_step = (idx_next == 4'(MAX_ROUNDS));

  assign chain[0] = state_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    ascon_round u_round (
      .state_i (chain[g]),
      .rc_i    (round_const(idx_q + 4'(g))),
      .state_o (chain[g+1])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fsm_q   <= ST_IDLE;
      idx_q   <= 4'd0;
      state_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (fsm_q)
        ST_IDLE: begin
          // Abort in IDLE suppresses the start entirely, including err_o.
          if (bus.start_i && !bus.abort_i) begin
            if (legal) begin
              state_q <= bus.state_i;
              idx_q   <= 4'(MAX_ROUNDS) - bus.rounds_i;
              fsm_q   <= ST_BUSY;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          // Abort wins over the final step: no round applied, no done_o.
          if (bus.abort_i) begin
            fsm_q <= ST_IDLE;
          end else begin
            state_q <= chain[UNROLL];
            idx_q   <= idx_next;
            if (last_step) begin
              fsm_q  <= ST_IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

`ifdef ASCON_PERM_INTR_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      intr_o <= 1'b0;
    end else if (done_q) begin
      intr_o <= 1'b1;
    end else if (intr_clr_i) begin
      intr_o <= 1'b0;
    end
  end
`endif

  assign bus.ready_o        = (fsm_q == ST_IDLE);
  assign bus.busy_o         = (fsm_q == ST_BUSY);
  assign bus.update_state_o = (fsm_q == ST_BUSY);
  assign bus.state_o        = state_q;
  assign bus.done_o         = done_q;
  assign bus.err_o          = err_q;
  assign bus.fsm_dbg_o      = fsm_e'(fsm_q);

endmodule
